// File: rtl/tube_pkg.sv
// Shared Tube ULA definitions: register-3 reset bytes and the one/two-byte mode
// encoding used by both directions of the register-3 FIFO.
package tube_pkg;

    localparam logic [7:0] TUBE_RST_BYTE0 = 8'hAA;
    localparam logic [7:0] TUBE_RST_BYTE1 = 8'hEE;

    typedef enum logic {
        REG3_TWO_BYTE = 1'b0,
        REG3_ONE_BYTE = 1'b1
    } reg3_mode_e;

    // Host-side full status: in one-byte mode only byte 0 matters.
    function automatic logic reg3_full(input reg3_mode_e mode, input logic f0, input logic f1);
        return (mode == REG3_ONE_BYTE) ? f0 : f1;
    endfunction

    // Empty status: byte 1 is invisible in one-byte mode.
    function automatic logic reg3_empty(input reg3_mode_e mode, input logic f0, input logic f1);
        return !f0 && (!f1 || (mode == REG3_ONE_BYTE));
    endfunction

endpackage

// File: rtl/tube_flag_sync.sv
// Single-clock occupancy flag with synchronous reset; a same-cycle set beats a clear.
module tube_flag_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);

    logic flag_q;
    logic flag_d;

    always_comb begin
        flag_d = flag_q;
        if (set_i) begin
            flag_d = 1'b1;
        end else if (clr_i) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/hp_reg3_sync.sv
// Host-to-parasite Tube register-3 FIFO (two bytes, single clock). Byte storage and
// output muxing live here; the occupancy flags are tube_flag_sync instances.
module hp_reg3_sync
    import tube_pkg::*;
#(
    parameter logic [7:0] RST_BYTE0 = TUBE_RST_BYTE0,
    parameter logic [7:0] RST_BYTE1 = TUBE_RST_BYTE1
) (
    input  logic       h_phi2,
    input  logic       h_rst,
    input  logic [7:0] h_data,
    input  logic       h_selectData,
    input  logic       h_wr,
    input  logic       p_selectData,
    input  logic       p_rd,
    input  logic       one_byte_mode,
    output logic [7:0] p_data,
    output logic       p_data_available,
    output logic       p_nmi,
    output logic       h_full,
    output logic       h_empty
);

    reg3_mode_e mode;
    logic       wr;
    logic       rd;
    logic       f0;
    logic       f1;
    logic       set0;
    logic       clr0;
    logic       set1;
    logic       clr1;
    logic [7:0] byte0_q;
    logic [7:0] byte0_d;
    logic [7:0] byte1_q;
    logic [7:0] byte1_d;

    assign mode = one_byte_mode ? REG3_ONE_BYTE : REG3_TWO_BYTE;
    assign wr   = h_selectData & h_wr;
    assign rd   = p_selectData & p_rd;

    // Everything is decoded from the pre-edge flags. In two-byte mode the set and
    // clear targets never coincide, so simultaneous accesses compose cleanly.
    always_comb begin
        set0 = 1'b0;
        clr0 = 1'b0;
        set1 = 1'b0;
        clr1 = 1'b0;
        unique case (mode)
            REG3_ONE_BYTE: begin
                set0 = wr;
                clr0 = rd;
            end
            REG3_TWO_BYTE: begin
                set0 = wr & !f0;
                set1 = wr & f0 & !f1;
                clr0 = rd & f0;
                clr1 = rd & !f0 & f1;
            end
            default: ;
        endcase
    end

    tube_flag_sync u_flag0 (
        .clk_i  (h_phi2),
        .rst_i  (h_rst),
        .set_i  (set0),
        .clr_i  (clr0),
        .flag_o (f0)
    );

    tube_flag_sync u_flag1 (
        .clk_i  (h_phi2),
        .rst_i  (h_rst),
        .set_i  (set1),
        .clr_i  (clr1),
        .flag_o (f1)
    );

    // A byte is captured exactly when its flag is being set, so dropped
    // overflow writes leave storage untouched.
    always_comb begin
        byte0_d = byte0_q;
        byte1_d = byte1_q;
        if (set0) begin
            byte0_d = h_data;
        end
        if (set1) begin
            byte1_d = h_data;
        end
    end

    always_ff @(posedge h_phi2) begin
        if (h_rst) begin
            byte0_q <= RST_BYTE0;
            byte1_q <= RST_BYTE1;
        end else begin
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
        end
    end

    assign p_data           = f0 ? byte0_q : byte1_q;
    assign p_data_available = (f0 & (mode == REG3_ONE_BYTE)) | f1;
    assign p_nmi            = p_data_available;
    assign h_full           = reg3_full(mode, f0, f1);
    assign h_empty          = reg3_empty(mode, f0, f1);

endmodule

// File: tb/tb_hp_reg3_sync.sv
// Self-checking bench for hp_reg3_sync: directed scenarios followed by randomized
// traffic compared against a slot-occupancy reference model.
module tb_hp_reg3_sync;

    logic       h_phi2 = 1'b0;
    logic       h_rst;
    logic [7:0] h_data;
    logic       h_selectData;
    logic       h_wr;
    logic       p_selectData;
    logic       p_rd;
    logic       one_byte_mode;
    logic [7:0] p_data;
    logic       p_data_available;
    logic       p_nmi;
    logic       h_full;
    logic       h_empty;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: two byte slots with occupancy bits.
    logic [7:0] mSlot [2];
    bit         mValid[2];
    bit         mOne;

    always #5 h_phi2 = ~h_phi2;

    hp_reg3_sync dut (
        .h_phi2           (h_phi2),
        .h_rst            (h_rst),
        .h_data           (h_data),
        .h_selectData     (h_selectData),
        .h_wr             (h_wr),
        .p_selectData     (p_selectData),
        .p_rd             (p_rd),
        .one_byte_mode    (one_byte_mode),
        .p_data           (p_data),
        .p_data_available (p_data_available),
        .p_nmi            (p_nmi),
        .h_full           (h_full),
        .h_empty          (h_empty)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One-byte mode is a single latch in slot 0; two-byte mode writes the lowest
    // empty slot and reads the lowest full slot, both judged on pre-edge occupancy.
    task automatic modelStep(input bit rst, input bit wr, input bit rd, input logic [7:0] d, input bit one);
        bit pv0, pv1;
        mOne = one;
        pv0 = mValid[0];
        pv1 = mValid[1];
        if (rst) begin
            mValid[0] = 0; mValid[1] = 0;
            mSlot[0] = 8'hAA; mSlot[1] = 8'hEE;
        end else if (one) begin
            if (wr) begin
                mSlot[0] = d; mValid[0] = 1;
            end else if (rd) begin
                mValid[0] = 0;
            end
        end else begin
            if (wr && !pv0) begin
                mSlot[0] = d; mValid[0] = 1;
            end else if (wr && !pv1) begin
                mSlot[1] = d; mValid[1] = 1;
            end
            if (rd && pv0) mValid[0] = 0;
            else if (rd && pv1) mValid[1] = 0;
        end
    endtask

    task automatic compareModel();
        logic [7:0] expData;
        bit expAvail, expFull, expEmpty;
        expData  = mValid[0] ? mSlot[0] : mSlot[1];
        expAvail = (mValid[0] && mOne) || mValid[1];
        expFull  = mOne ? mValid[0] : mValid[1];
        expEmpty = !mValid[0] && (!mValid[1] || mOne);
        checkOutput("p_data",  p_data, expData);
        checkOutput("avail",   {7'b0, p_data_available}, {7'b0, expAvail});
        checkOutput("p_nmi",   {7'b0, p_nmi}, {7'b0, expAvail});
        checkOutput("h_full",  {7'b0, h_full}, {7'b0, expFull});
        checkOutput("h_empty", {7'b0, h_empty}, {7'b0, expEmpty});
    endtask

    task automatic applyStimulus(input bit rst, input bit hSel, input bit hWr, input bit pSel,
                                 input bit pRd, input logic [7:0] d, input bit one);
        h_rst = rst; h_selectData = hSel; h_wr = hWr;
        p_selectData = pSel; p_rd = pRd; h_data = d; one_byte_mode = one;
        @(posedge h_phi2);
        modelStep(rst, hSel && hWr, pSel && pRd, d, one);
        #1;
        compareModel();
    endtask

    task automatic hostWrite(input logic [7:0] d, input bit one);
        applyStimulus(0, 1, 1, 0, 0, d, one);
    endtask

    task automatic paraRead(input bit one);
        applyStimulus(0, 0, 0, 1, 1, 8'h00, one);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        h_rst = 1; h_data = 0; h_selectData = 0; h_wr = 0;
        p_selectData = 0; p_rd = 0; one_byte_mode = 0;

        applyStimulus(1, 0, 0, 0, 0, 8'h00, 0);
        checkOutput("rst_pdata", p_data, 8'hEE);
        checkOutput("rst_empty", {7'b0, h_empty}, 8'h01);
        checkOutput("rst_full",  {7'b0, h_full}, 8'h00);

        // Two-byte transfer
        hostWrite(8'h12, 0);
        checkOutput("tb_avail_1st", {7'b0, p_data_available}, 8'h00);
        hostWrite(8'h34, 0);
        checkOutput("tb_avail_2nd", {7'b0, p_data_available}, 8'h01);
        checkOutput("tb_full", {7'b0, h_full}, 8'h01);
        checkOutput("tb_rd0", p_data, 8'h12);
        paraRead(0);
        checkOutput("tb_rd1", p_data, 8'h34);
        checkOutput("tb_avail_mid", {7'b0, p_data_available}, 8'h01);
        paraRead(0);
        checkOutput("tb_avail_end", {7'b0, p_data_available}, 8'h00);
        checkOutput("tb_empty_end", {7'b0, h_empty}, 8'h01);

        // Overflow: third byte dropped
        hostWrite(8'h01, 0);
        hostWrite(8'h02, 0);
        hostWrite(8'h03, 0);
        checkOutput("ovf_rd0", p_data, 8'h01);
        paraRead(0);
        checkOutput("ovf_rd1", p_data, 8'h02);
        paraRead(0);
        checkOutput("ovf_empty", {7'b0, h_empty}, 8'h01);

        // One-byte mode
        hostWrite(8'h55, 1);
        checkOutput("ob_avail", {7'b0, p_data_available}, 8'h01);
        checkOutput("ob_full", {7'b0, h_full}, 8'h01);
        hostWrite(8'h66, 1);
        checkOutput("ob_overwrite", p_data, 8'h66);
        paraRead(1);
        checkOutput("ob_avail_rd", {7'b0, p_data_available}, 8'h00);
        checkOutput("ob_empty_rd", {7'b0, h_empty}, 8'h01);

        // Simultaneous write and read with f0=0, f1=1
        hostWrite(8'h11, 0);
        hostWrite(8'h22, 0);
        paraRead(0);
        checkOutput("sim_byte1", p_data, 8'h22);
        applyStimulus(0, 1, 1, 1, 1, 8'h77, 0);
        checkOutput("sim_pdata", p_data, 8'h77);
        checkOutput("sim_empty", {7'b0, h_empty}, 8'h00);
        checkOutput("sim_avail", {7'b0, p_data_available}, 8'h00);
        paraRead(0);

        // Reset mid-transfer beats a concurrent write
        hostWrite(8'h99, 0);
        applyStimulus(1, 1, 1, 0, 0, 8'h88, 0);
        checkOutput("rstmid_empty", {7'b0, h_empty}, 8'h01);
        checkOutput("rstmid_pdata", p_data, 8'hEE);
        checkOutput("rstmid_avail", {7'b0, p_data_available}, 8'h00);

        // Randomized traffic, including occasional resets and mode flips
        begin
            bit one = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 19) == 0) one = ~one;
                applyStimulus($urandom_range(0, 49) == 0,
                              $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                              $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                              8'($urandom), one);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
